// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared definitions for the pipeline front-end controller:
//           front-end state encoding, squash instruction, reset PC default.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Front-end sequencing state, as seen on the 2-bit state output
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LU   = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // addi x0,x0,0 -- loaded into IF/ID whenever the slot is squashed
  localparam logic [31:0] PKG_NOP_INSTR = 32'h0000_0013;

  // Fetch address after reset
  localparam logic [31:0] PKG_RESET_PC  = 32'h0000_0000;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Width-parameterised saturating up-counter. Sticks at all-ones
//           instead of wrapping. Synchronous active-low clear.
// Ports   : clk    in  1      rising-edge clock
//           clr_n  in  1      synchronous active-low clear
//           inc    in  1      increment request
//           count  out WIDTH  current count
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl
// Purpose : Pipeline front-end controller. Owns the PC and IF/ID register,
//           sequences load-use hold, EX redirect squash and halt, drives the
//           ID/EX bubble request and keeps stall/flush performance counters.
// Ports   : clk, rst_n               clock, sync active-low reset
//           if_instr                 instruction fetched at pc
//           fwd_stall, fwd_flush     load-use hold / ID-EX bubble requests
//           halt                     halt request from ID
//           ex_redirect, ex_target   taken branch/jump from EX
//           pc                       current fetch address
//           ifid_pc/instr/valid      IF/ID register contents
//           idex_bubble              combinational bubble for ID/EX
//           state                    RUN=0, LU=1, HALT=2
//           stall_cnt, flush_cnt     saturating performance counters
//           proto_err, misalign      sticky error flags
// Revision: 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = PKG_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = PKG_NOP_INSTR,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_instr,
  input  logic             fwd_stall,
  input  logic             fwd_flush,
  input  logic             halt,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  ifid_pc,
  output logic [XLEN-1:0]  ifid_instr,
  output logic             ifid_valid,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             proto_err,
  output logic             misalign
);

  state_t            state_q, state_nxt;
  logic [XLEN-1:0]   pc_nxt, ifid_pc_nxt, ifid_instr_nxt;
  logic              ifid_valid_nxt, proto_err_nxt, misalign_nxt;
  logic              stall_eff, stall_inc, flush_inc;

  // A stall only takes hold from RUN and loses to redirect and halt
  assign stall_eff = fwd_stall && (state_q == ST_RUN) && !ex_redirect && !halt;

  assign idex_bubble = !rst_n || ex_redirect || stall_eff
                     || (fwd_flush && (state_q == ST_RUN))
                     || (state_q == ST_HALT);

  always_comb begin
    state_nxt      = state_q;
    pc_nxt         = pc;
    ifid_pc_nxt    = ifid_pc;
    ifid_instr_nxt = ifid_instr;
    ifid_valid_nxt = ifid_valid;
    proto_err_nxt  = proto_err;
    misalign_nxt   = misalign;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    if (state_q == ST_HALT) begin
      // EX carries only bubbles here, so a redirect cannot be genuine
      ifid_valid_nxt = 1'b0;
    end else if (ex_redirect) begin
      pc_nxt         = {ex_target[XLEN-1:2], 2'b00};
      ifid_pc_nxt    = pc;
      ifid_instr_nxt = NOP_INSTR;
      ifid_valid_nxt = 1'b0;
      state_nxt      = ST_RUN;
      flush_inc      = 1'b1;
      if (ex_target[1:0] != 2'b00) begin
        misalign_nxt = 1'b1;
      end
    end else if (halt) begin
      ifid_valid_nxt = 1'b0;
      state_nxt      = ST_HALT;
    end else if (stall_eff) begin
      state_nxt      = ST_LU;
      stall_inc      = 1'b1;
    end else begin
      // A second consecutive stall request is a forwarding-unit bug;
      // flag it but never hold longer than one cycle.
      if ((state_q == ST_LU) && fwd_stall) begin
        proto_err_nxt = 1'b1;
      end
      pc_nxt         = pc + XLEN'(4);
      ifid_pc_nxt    = pc;
      ifid_instr_nxt = if_instr;
      ifid_valid_nxt = 1'b1;
      state_nxt      = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      proto_err  <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      pc         <= pc_nxt;
      ifid_pc    <= ifid_pc_nxt;
      ifid_instr <= ifid_instr_nxt;
      ifid_valid <= ifid_valid_nxt;
      proto_err  <= proto_err_nxt;
      misalign   <= misalign_nxt;
    end
  end

  assign state = state_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_ctrl
// Purpose : Self-checking bench for pipe_ctrl (CNT_W=2 so saturation is
//           reachable). Expected register contents are pushed to a queue as
//           each cycle is driven and popped after the clock edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int CW = 2;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n, fwd_stall, fwd_flush, halt, ex_redirect;
  logic [31:0]   if_instr, ex_target;
  logic [31:0]   pc, ifid_pc, ifid_instr;
  logic          ifid_valid, idex_bubble, proto_err, misalign;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(32'h13), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .fwd_stall(fwd_stall),
    .fwd_flush(fwd_flush), .halt(halt), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .pc(pc), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .idex_bubble(idex_bubble), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .proto_err(proto_err),
    .misalign(misalign)
  );

  typedef struct {
    logic [31:0]   pc, ifid_pc, ifid_instr;
    logic          valid;
    logic [1:0]    st;
    logic [CW-1:0] sc, fc;
    logic          pe, mis;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [31:0]   m_pc = 32'h0, m_ifid_pc = 32'h0, m_ifid_instr = 32'h13;
  logic          m_valid = 1'b0, m_pe = 1'b0, m_mis = 1'b0;
  logic [1:0]    m_st = 2'd0;
  logic [CW-1:0] m_sc = '0, m_fc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive, check combinational bubble, advance model,
  // push expectation, clock, pop and compare.
  task automatic step(input logic r, input logic [31:0] ins, input logic st,
                      input logic fl, input logic hl, input logic rd,
                      input logic [31:0] tg);
    logic exp_b;
    exp_t e;
    rst_n = r; if_instr = ins; fwd_stall = st; fwd_flush = fl;
    halt = hl; ex_redirect = rd; ex_target = tg;
    #1;
    exp_b = !r || rd || (st && m_st == 2'd0 && !rd && !hl)
          || (fl && m_st == 2'd0) || (m_st == 2'd2);
    check("idex_bubble", {31'b0, idex_bubble}, {31'b0, exp_b});

    if (!r) begin
      m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = 32'h13; m_valid = 1'b0;
      m_st = 2'd0; m_sc = '0; m_fc = '0; m_pe = 1'b0; m_mis = 1'b0;
    end else if (m_st == 2'd2) begin
      m_valid = 1'b0;
    end else if (rd) begin
      m_ifid_pc = m_pc; m_ifid_instr = 32'h13; m_valid = 1'b0;
      m_pc = {tg[31:2], 2'b00}; m_st = 2'd0;
      if (m_fc != CMAX) m_fc = m_fc + 1'b1;
      if (tg[1:0] != 2'b00) m_mis = 1'b1;
    end else if (hl) begin
      m_valid = 1'b0; m_st = 2'd2;
    end else if (st && m_st == 2'd0) begin
      m_st = 2'd1;
      if (m_sc != CMAX) m_sc = m_sc + 1'b1;
    end else begin
      if (st && m_st == 2'd1) m_pe = 1'b1;
      m_ifid_pc = m_pc; m_ifid_instr = ins; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_st = 2'd0;
    end
    sb.push_back('{m_pc, m_ifid_pc, m_ifid_instr, m_valid, m_st, m_sc, m_fc, m_pe, m_mis});

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pc",         pc,                      e.pc);
    check("ifid_pc",    ifid_pc,                 e.ifid_pc);
    check("ifid_instr", ifid_instr,              e.ifid_instr);
    check("ifid_valid", {31'b0, ifid_valid},     {31'b0, e.valid});
    check("state",      {30'b0, state},          {30'b0, e.st});
    check("stall_cnt",  {30'b0, stall_cnt},      {30'b0, e.sc});
    check("flush_cnt",  {30'b0, flush_cnt},      {30'b0, e.fc});
    check("proto_err",  {31'b0, proto_err},      {31'b0, e.pe});
    check("misalign",   {31'b0, misalign},       {31'b0, e.mis});
  endtask

  task automatic adv();
    step(1'b1, m_pc ^ 32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_stall();
    step(1'b1, m_pc ^ 32'h0050_0093, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; if_instr = '0; fwd_stall = 1'b0; fwd_flush = 1'b0;
    halt = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    @(posedge clk); #1;

    // Reset and sequential fetch
    do_reset(); do_reset();
    check("tp_rst_valid", {31'b0, ifid_valid}, 32'd0);
    adv();
    check("tp_first_ifid_pc", ifid_pc, 32'h0);
    check("tp_first_instr", ifid_instr, 32'h0050_0093);
    check("tp_first_valid", {31'b0, ifid_valid}, 32'd1);
    adv();
    check("tp_pc8", pc, 32'h8);
    adv(); adv();
    check("tp_pc10", pc, 32'h10);

    // Load-use: one hold cycle
    do_stall();
    check("tp_lu_hold", pc, 32'h10);
    check("tp_lu_state", {30'b0, state}, 32'd1);
    adv();
    check("tp_lu_resume", pc, 32'h14);
    check("tp_lu_cnt", {30'b0, stall_cnt}, 32'd1);

    // Redirect beats stall and halt
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
    check("tp_rd_pc", pc, 32'h100);
    check("tp_rd_instr", ifid_instr, 32'h13);
    check("tp_rd_fc", {30'b0, flush_cnt}, 32'd1);
    check("tp_rd_sc", {30'b0, stall_cnt}, 32'd1);

    // Two consecutive stall requests: one hold, proto_err
    do_stall(); do_stall();
    check("tp_pe", {31'b0, proto_err}, 32'd1);
    check("tp_pe_pc", pc, 32'h104);

    // Flush alone: bubble, normal advance
    step(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("tp_flush_pc", pc, 32'h108);

    // Misaligned redirect
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h102);
    check("tp_mis_pc", pc, 32'h100);
    check("tp_mis", {31'b0, misalign}, 32'd1);

    // Halt: frozen, redirect ignored, reset leaves
    do_reset();
    repeat (8) adv();
    check("tp_halt_start", pc, 32'h20);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, (i == 4), 32'h200);
    end
    check("tp_halt_pc", pc, 32'h20);
    check("tp_halt_state", {30'b0, state}, 32'd2);
    check("tp_halt_fc", {30'b0, flush_cnt}, 32'd0);
    do_reset();
    check("tp_halt_rst_pc", pc, 32'h0);
    check("tp_halt_rst_st", {30'b0, state}, 32'd0);

    // Saturation of both counters
    for (int i = 0; i < 5; i++) begin
      do_stall(); adv();
    end
    check("tp_sat_sc", {30'b0, stall_cnt}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    end
    check("tp_sat_fc", {30'b0, flush_cnt}, 32'd3);

    // pc+4 wraps
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    adv();
    check("tp_wrap", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_ctrl
`default_nettype wire
